cordic_rr_sched: RTL
====================

# cordic_rr_sched

Round-robin scheduler that shares one iterative CORDIC rotation core among NREQ requesters. It accepts (angle, xin, yin) jobs from requesters through a valid/ready handshake and range-checks the angle. It launches the core with a one-cycle start pulse, waits for the core's done pulse under a watchdog, and returns the rotated result tagged with the requester id. It sits between the DSP clients and the single cordic instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, signed operand/result width
- ANG_MAX, 9000, max legal |angle| in hundredths of a degree (core scale: 4500 = 45.00°)
- WAIT_MAX, 32, watchdog limit in cycles for core_done after core_start
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester job request
- req_ready  out  NREQ  one-hot accept pulse
- req_angle / req_xin / req_yin  in  NREQ*W each  flattened operands, requester i at bits [i*W +: W]
- core_start  out  1  one-cycle launch pulse to the core
- core_angle / core_xin / core_yin  out  W each  operands to the core, held stable from core_start until the response
- core_done  in  1  one-cycle completion pulse from the core
- core_xout / core_yout  in  W each  core results, valid in the core_done cycle
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  clog2(NREQ)  requester that owns the result
- rsp_xout / rsp_yout  out  W each  result
- rsp_err  out  1  qualifies rsp_valid: angle rejected or watchdog expired
- busy  out  1  state != IDLE

## Operation
- States: IDLE, GRANT, START, WAIT, RESP.
- IDLE:
  - If any req_valid is set, select the winner by round-robin, starting at index ptr+1 mod NREQ and searching upward with wrap.
  - Register the winner into gnt and go to GRANT.
- GRANT:
  - req_ready[gnt]=1 for exactly this cycle.
  - Latch that requester's operands into internal registers at the closing edge.
  - Set ptr=gnt.
  - If |angle| > ANG_MAX, go to RESP with err=1 and results 0. Otherwise go to START.
- START:
  - core_start=1 for one cycle.
  - Clear the watchdog counter to 0. Go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On core_done, capture core_xout/core_yout with err=0 and go to RESP.
  - If the counter reaches WAIT_MAX-1 without core_done, go to RESP with err=1 and results 0.
  - If core_done and the expiry coincide, core_done wins.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id=gnt, rsp_xout/rsp_yout and rsp_err.
  - Go to IDLE.
- Requesters must hold req_valid and operands stable until their req_ready. A requester that drops req_valid before its GRANT cycle still has its current operands latched; that is a protocol violation and gets no special handling.
- core_done outside WAIT is ignored.
- The angle check is signed: -ANG_MAX and +ANG_MAX are legal; -ANG_MAX-1 is rejected.
- core_* operand outputs are driven from the latched registers at all times.
- Reset values:
  - req_ready=0, core_start=0, rsp_valid=0, rsp_err=0, busy=0.
  - rsp_id=0, rsp_xout/rsp_yout=0.
  - core operand registers=0, ptr=NREQ-1, so requester 0 wins first. Counter=0.
- Reset mid-operation: return to IDLE immediately, emit no response, drop any in-flight job. A core_done arriving later is ignored.

## Timing
- Cycle 0: IDLE samples req_valid.
- Cycle 1: req_ready pulse (GRANT).
- Cycle 2: core_start (START).
- Cycle 2+L: core_done, for a core latency of L ≥ 1 cycles after start.
- Cycle 3+L: rsp_valid.
- Cycle 4+L: IDLE; the next grant pulse appears at 5+L at the earliest.
- Rejected angle: rsp_valid at cycle 2, no core_start.
- Watchdog: rsp_valid with err at cycle 3+WAIT_MAX.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- Single request on requester 2: angle=3000, xin=1000, yin=0; core model with L=9 returns (866,500) → req_ready[2] at cycle 1, core_start at cycle 2, rsp_valid at cycle 12 with id=2, xout=866, yout=500, err=0.
- All four requesters held valid continuously from reset → grant order 0,1,2,3,0; exactly one core_start per response.
- angle=9001 on requester 1 → rsp_valid at cycle 2 with id=1, err=1, results 0, no core_start. angle=-9000 → core is launched.
- Core model never asserts done, WAIT_MAX=32 → rsp_err=1 at cycle 35, then state returns to IDLE. Repeat with core_done in the expiry cycle → err=0 and the captured result is returned.
- Reset asserted during WAIT, then a late core_done → no rsp_valid; after reset, requester 0 wins first. Also pulse core_done in IDLE → ignored.

Source files
------------

// File: rtl/cordic_rr_sched.sv
// Round-robin front end that shares one iterative CORDIC rotation core among NREQ
// requesters: accepts jobs, range-checks the angle, launches the core under a watchdog.
module cordic_rr_sched #(
    parameter int NREQ     = 4,
    parameter int W        = 16,
    parameter int ANG_MAX  = 9000,
    parameter int WAIT_MAX = 32,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(WAIT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_angle,
    input  logic [NREQ*W-1:0] req_xin,
    input  logic [NREQ*W-1:0] req_yin,
    output logic              core_start,
    output logic [W-1:0]      core_angle,
    output logic [W-1:0]      core_xin,
    output logic [W-1:0]      core_yin,
    input  logic              core_done,
    input  logic [W-1:0]      core_xout,
    input  logic [W-1:0]      core_yout,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_xout,
    output logic [W-1:0]      rsp_yout,
    output logic              rsp_err,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    // Handshake: a requester raises req_valid with stable operands and holds both until
    // the single-cycle req_ready pulse on its own bit; the job is accepted in that cycle.

    logic [2:0]     state;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;

    logic [IDW-1:0] rr_win;
    logic [IDW-1:0] rr_idx;
    logic           rr_found;
    logic [W-1:0]   sel_angle;
    logic [W-1:0]   sel_xin;
    logic [W-1:0]   sel_yin;
    int             ang_i;
    logic           ang_bad;

    assign dbg_state = state;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        rr_win   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = IDW'((int'(ptr) + 1 + k) % NREQ);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    always_comb begin
        sel_angle = '0;
        sel_xin   = '0;
        sel_yin   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_angle = req_angle[i*W +: W];
                sel_xin   = req_xin[i*W +: W];
                sel_yin   = req_yin[i*W +: W];
            end
        end
    end

    // Signed range check: both +ANG_MAX and -ANG_MAX are legal.
    always_comb begin
        ang_i   = int'(signed'(sel_angle));
        ang_bad = (ang_i > ANG_MAX) || (ang_i < -ANG_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            gnt        <= '0;
            ptr        <= IDW'(NREQ - 1);
            cnt        <= '0;
            req_ready  <= '0;
            core_start <= 1'b0;
            core_angle <= '0;
            core_xin   <= '0;
            core_yin   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_xout   <= '0;
            rsp_yout   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            req_ready  <= '0;
            core_start <= 1'b0;
            rsp_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        gnt       <= rr_win;
                        req_ready <= NREQ'(1) << rr_win;
                        state     <= S_GRANT;
                        busy      <= 1'b1;
                    end
                end
                S_GRANT: begin
                    core_angle <= sel_angle;
                    core_xin   <= sel_xin;
                    core_yin   <= sel_yin;
                    ptr        <= gnt;
                    if (ang_bad) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_id    <= gnt;
                        rsp_xout  <= '0;
                        rsp_yout  <= '0;
                    end else begin
                        state      <= S_START;
                        core_start <= 1'b1;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // core_done takes priority over a watchdog expiry in the same cycle.
                    if (core_done) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_id    <= gnt;
                        rsp_xout  <= core_xout;
                        rsp_yout  <= core_yout;
                    end else if (cnt == CW'(WAIT_MAX - 1)) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_id    <= gnt;
                        rsp_xout  <= '0;
                        rsp_yout  <= '0;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
